// File: rtl/alu_op_dispatcher.sv
// Issue/capture sequencer for a bank of enable-gated combinational ALU op blocks.
// Optional macro ALU_PARITY_EN adds a registered rsp_parity output (^rsp_data).
module alu_op_dispatcher #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int OP_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  output logic [NUM_OPS-1:0]       op_en,
  input  logic [NUM_OPS*WIDTH-1:0] op_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_zero,
  output logic                     rsp_err
`ifdef ALU_PARITY_EN
  ,
  output logic                     rsp_parity
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, RESP} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [NUM_OPS-1:0]   op_en_q, op_en_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_err_q, rsp_err_d;
`ifdef ALU_PARITY_EN
  logic                 rsp_parity_q, rsp_parity_d;
`endif

  logic                 op_ok;
  logic [NUM_OPS-1:0]   en_dec;
  logic [WIDTH-1:0]     res_or;
  logic [WIDTH-1:0]     cap_data;
  logic                 accept;

  assign accept = (state_q == IDLE) && cmd_valid;

  always_comb begin
    op_ok = (int'(cmd_op) < NUM_OPS);
    for (int k = 0; k < NUM_OPS; k++) begin
      en_dec[k] = op_ok && (int'(cmd_op) == k);
    end
  end

  // Disabled blocks drive zero, so OR-ing every slice yields the selected result.
  always_comb begin
    res_or = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      res_or = res_or | op_res[k*WIDTH +: WIDTH];
    end
    cap_data = err_q ? '0 : res_or;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = DRIVE;
      DRIVE:   state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_en_d    = op_en_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
`ifdef ALU_PARITY_EN
    rsp_parity_d = rsp_parity_q;
`endif
    if (accept) begin
      op_a_d  = cmd_a;
      op_b_d  = cmd_b;
      op_en_d = en_dec;
      err_d   = !op_ok;
    end else if (state_q == DRIVE) begin
      // Sample the blocks while op_en is still asserted, then release the enable.
      op_en_d    = '0;
      rsp_data_d = cap_data;
      rsp_zero_d = (cap_data == '0);
      rsp_err_d  = err_q;
`ifdef ALU_PARITY_EN
      rsp_parity_d = ^cap_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_en_q    <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
`ifdef ALU_PARITY_EN
      rsp_parity_q <= 1'b0;
`endif
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_en_q    <= op_en_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
`ifdef ALU_PARITY_EN
      rsp_parity_q <= rsp_parity_d;
`endif
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_en    = op_en_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;
`ifdef ALU_PARITY_EN
  assign rsp_parity = rsp_parity_q;
`endif

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Self-checking bench for alu_op_dispatcher with AND/OR/XOR blocks at indices 0..2.
module tb_alu_op_dispatcher;
  localparam int WIDTH   = 4;
  localparam int NUM_OPS = 3;
  localparam int OP_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [OP_W-1:0]          cmd_op;
  logic [WIDTH-1:0]         cmd_a;
  logic [WIDTH-1:0]         cmd_b;
  logic [WIDTH-1:0]         op_a;
  logic [WIDTH-1:0]         op_b;
  logic [NUM_OPS-1:0]       op_en;
  logic [NUM_OPS*WIDTH-1:0] op_res;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_zero;
  logic                     rsp_err;
`ifdef ALU_PARITY_EN
  logic                     rsp_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_dispatcher #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .OP_W(OP_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .op_a(op_a),
    .op_b(op_b),
    .op_en(op_en),
    .op_res(op_res),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_zero(rsp_zero),
`ifdef ALU_PARITY_EN
    .rsp_parity(rsp_parity),
`endif
    .rsp_err(rsp_err)
  );

  // Gated op blocks: output zero unless enabled.
  assign op_res[0*WIDTH +: WIDTH] = op_en[0] ? (op_a & op_b) : '0;
  assign op_res[1*WIDTH +: WIDTH] = op_en[1] ? (op_a | op_b) : '0;
  assign op_res[2*WIDTH +: WIDTH] = op_en[2] ? (op_a ^ op_b) : '0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [WIDTH-1:0] model_res(input int op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [NUM_OPS-1:0] model_en(input int op);
    logic [NUM_OPS-1:0] r;
    r = '0;
    if (op < NUM_OPS) r[op] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input string tag);
    logic [WIDTH-1:0] r;
    r = model_res(op, a, b);
    cmd_op    = op[OP_W-1:0];
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    chk({tag, "_rdy0"}, 32'(cmd_ready), 32'd1);
    step;
    cmd_valid = 1'b0;
    chk({tag, "_en"}, 32'(op_en), 32'(model_en(op)));
    chk({tag, "_rdy1"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_vld1"}, 32'(rsp_valid), 32'd0);
    step;
    chk({tag, "_enclr"}, 32'(op_en), 32'd0);
    chk({tag, "_vld2"}, 32'(rsp_valid), 32'd0);
    step;
    chk({tag, "_vld3"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(r));
    chk({tag, "_zero"}, 32'(rsp_zero), 32'(r == '0));
    chk({tag, "_err"}, 32'(rsp_err), 32'(op >= NUM_OPS));
    chk({tag, "_opa"}, 32'(op_a), 32'(a));
`ifdef ALU_PARITY_EN
    chk({tag, "_par"}, 32'(rsp_parity), 32'(^r));
`endif
    step;
    chk({tag, "_vld4"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy4"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int   nresp;
    int   last_acc;
    logic accepting;
    logic just_acc;
    logic [NUM_OPS-1:0] last_en;
    exp_t e;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_rdy", 32'(cmd_ready), 32'd1);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_en", 32'(op_en), 32'd0);
    chk("rst_opa", 32'(op_a), 32'd0);
    chk("rst_opb", 32'(op_b), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step;

    run_cmd(0, 4'b1100, 4'b1010, "and_nz");
    run_cmd(0, 4'b0101, 4'b1010, "and_z");
    run_cmd(3, 4'b1111, 4'b1111, "inv_op");
    run_cmd(1, 4'b0100, 4'b0001, "or");
    run_cmd(2, 4'b1111, 4'b1111, "xor_z");

    // Backpressure: response must stay put while rsp_ready is low.
    cmd_op    = 2'd2;
    cmd_a     = 4'b0110;
    cmd_b     = 4'b0011;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    step;
    cmd_valid = 1'b0;
    step;
    step;
    chk("bp_vld0", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = ~cmd_valid;
      cmd_op    = OP_W'($urandom_range(0, 2));
      cmd_a     = WIDTH'($urandom);
      cmd_b     = WIDTH'($urandom);
      step;
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'b0101);
      chk("bp_zero", 32'(rsp_zero), 32'd0);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_rdy", 32'(cmd_ready), 32'd0);
      chk("bp_en", 32'(op_en), 32'd0);
    end
    chk("bp_opa_kept", 32'(op_a), 32'b0110);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step;
    chk("bp_rel_vld", 32'(rsp_valid), 32'd0);
    chk("bp_rel_rdy", 32'(cmd_ready), 32'd1);

    // Asynchronous reset while a response is pending.
    cmd_op    = 2'd1;
    cmd_a     = 4'b1001;
    cmd_b     = 4'b0010;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    step;
    cmd_valid = 1'b0;
    step;
    step;
    chk("mid_vld", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rdy", 32'(cmd_ready), 32'd1);
    chk("mrst_vld", 32'(rsp_valid), 32'd0);
    chk("mrst_en", 32'(op_en), 32'd0);
    chk("mrst_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step;

    // Asynchronous reset while the enable is driven.
    cmd_op    = 2'd0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step;
    cmd_valid = 1'b0;
    chk("drst_en0", 32'(op_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("drst_en", 32'(op_en), 32'd0);
    chk("drst_rdy", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step;

    // Back-to-back random commands with a scoreboard.
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    cmd_op    = OP_W'($urandom_range(0, 3));
    cmd_a     = WIDTH'($urandom);
    cmd_b     = WIDTH'($urandom);
    nresp     = 0;
    last_acc  = -1;
    just_acc  = 1'b0;
    last_en   = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_spurious", 32'd1, 32'(exp_q.size()));
        end else begin
          e = exp_q.pop_front();
          chk("b2b_data", 32'(rsp_data), 32'(e.res));
          chk("b2b_zero", 32'(rsp_zero), 32'(e.zero));
          chk("b2b_err", 32'(rsp_err), 32'(e.err));
          nresp++;
        end
      end
      if (just_acc) chk("b2b_en", 32'(op_en), 32'(last_en));
      accepting = cmd_ready;
      if (accepting) begin
        e.res  = model_res(int'(cmd_op), cmd_a, cmd_b);
        e.zero = (e.res == '0);
        e.err  = (int'(cmd_op) >= NUM_OPS);
        exp_q.push_back(e);
        last_en = model_en(int'(cmd_op));
        if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
      end
      step;
      just_acc = accepting;
      if (accepting) begin
        cmd_op = OP_W'($urandom_range(0, 3));
        cmd_a  = WIDTH'($urandom);
        cmd_b  = WIDTH'($urandom);
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_count", 32'(nresp >= 45), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
